vga_scan_gen: RTL and testbench
===============================

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameter DIV, 4, clk cycles per pixel; legal range 1..16.
REQ-002 Parameter H_VIS, 640, visible pixels per line.
REQ-003 Parameter H_FP / H_SW / H_BP, 16 / 96 / 48, horizontal front porch / sync width / back porch in pixels.
REQ-004 Parameter V_VIS, 480, visible lines per frame.
REQ-005 Parameter V_FP / V_SW / V_BP, 10 / 2 / 33, vertical front porch / sync width / back porch in lines.
REQ-006 clk  in  1  system clock, all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 en  in  1  scan enable; low freezes the whole scan.
REQ-009 h_cnt  out  10  current pixel column, 0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SW+H_BP (800).
REQ-010 v_cnt  out  10  current line, 0..V_TOT-1, where V_TOT = V_VIS+V_FP+V_SW+V_BP (525).
REQ-011 valid  out  1  high while (h_cnt, v_cnt) is in the visible area.
REQ-012 hsync  out  1  horizontal sync, active-low.
REQ-013 vsync  out  1  vertical sync, active-low.
REQ-014 pix_tick  out  1  high in the last clk cycle of each pixel; sprite consumers sample colour on it.
REQ-015 frame_start  out  1  one-cycle pulse when the scan re-enters (0,0) after a frame wrap.
REQ-016 vblank_start  out  1  one-cycle pulse when v_cnt becomes V_VIS with h_cnt = 0.
REQ-017 frame_cnt  out  16  completed-frame counter.

Function
REQ-018 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-019 Divider div_cnt SHALL count 0..DIV-1 and wrap; it advances only while en = 1.
REQ-020 pix_tick SHALL be 1 exactly when en = 1 and div_cnt = DIV-1; with DIV = 1 it equals en.
REQ-021 h_cnt SHALL increment at the clk edge that ends a pix_tick cycle, holding DIV cycles per value while en = 1.
REQ-022 h_cnt SHALL wrap from H_TOT-1 to 0, and v_cnt SHALL increment on that same edge.
REQ-023 v_cnt SHALL wrap from V_TOT-1 to 0 on a line wrap, and frame_cnt SHALL increment (mod 2^16) on that same edge.
REQ-024 valid SHALL be 1 iff h_cnt < H_VIS and v_cnt < V_VIS, aligned to the same cycle as the counters it describes.
REQ-025 hsync SHALL be 0 iff H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SW (656..751), cycle-aligned to h_cnt.
REQ-026 vsync SHALL be 0 iff V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SW (490..491), cycle-aligned to v_cnt.
REQ-027 frame_start SHALL be high for only the first clk cycle after the frame-wrap edge; it is not asserted after reset release.
REQ-028 vblank_start SHALL be high for only the first clk cycle in which v_cnt = V_VIS and h_cnt = 0.
REQ-029 With en = 0, the divider, counters, sync outputs, valid and frame_cnt SHALL hold, and pix_tick, frame_start and vblank_start SHALL be 0.
REQ-030 Freeze and resume SHALL be lossless: on en returning to 1, the divider resumes from the held div_cnt, so no partial pixel is lost or repeated.
REQ-031 Counter arithmetic SHALL be 10-bit unsigned; illegal values (h_cnt >= H_TOT, v_cnt >= V_TOT) are unreachable.

Reset
REQ-032 While rst = 1, the block SHALL hold: div_cnt = 0, h_cnt = 0, v_cnt = 0, frame_cnt = 0, valid = 0, hsync = 1, vsync = 1, pix_tick = 0, frame_start = 0, vblank_start = 0.
REQ-033 From the first edge with rst = 0, valid, hsync and vsync SHALL reflect the counters; (0,0) therefore gives valid = 1 in the first post-reset cycle.
REQ-034 rst asserted mid-line or mid-frame SHALL return to the reset values on the next edge, with no pulses generated.
REQ-035 rst SHALL take priority over en.

Verification
REQ-036 Reset release, en = 1: h_cnt steps 0 -> 1 after 4 clks, pix_tick is high every 4th clk, and the line period is 3200 clks.
REQ-037 hsync low for exactly 384 clks per line, starting when h_cnt = 656; valid low for h_cnt 640..799.
REQ-038 Full frame: 1,680,000 clks between frame_start pulses; vsync low for 6400 clks at v_cnt 490..491; vblank_start once per frame at v_cnt = 480; frame_cnt 0 -> 1.
REQ-039 en dropped for 100 clks at h_cnt = 799, v_cnt = 524, div_cnt = 2: all outputs hold; after en rises, the wrap occurs 2 clks later with frame_start = 1 and frame_cnt incremented.
REQ-040 rst pulsed at h_cnt = 300, v_cnt = 200: next cycle shows all reset values, no frame_start; the scan restarts from (0,0).
REQ-041 DIV = 1 build: pix_tick is constantly 1 with en = 1, and the line period is 800 clks.

Source files
------------

// File: rtl/vga_scan_gen.sv
// ---------------------------------------------------------------------------
// vga_scan_gen
//
// Purpose:
//   Pixel-clock divider and raster scan generator for a VGA-style display.
//   A clk-rate divider produces one pixel every DIV clk cycles. Each pixel
//   advances a column counter, and each line wrap advances a line counter.
//   Frame wraps advance a completed-frame counter. The block also produces
//   the visible-area flag, active-low sync pulses, and one-cycle event
//   pulses for pixel, frame start and vertical-blank start.
//
//   Every output comes straight from a flop. Each flop's next value is
//   computed from the next counter values, so the decoded outputs stay
//   cycle-aligned with the counters they describe.
//
// Parameters:
//   DIV                   clk cycles per pixel (1..16)
//   H_VIS/H_FP/H_SW/H_BP  horizontal visible / front porch / sync / back porch
//   V_VIS/V_FP/V_SW/V_BP  vertical visible / front porch / sync / back porch
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset, wins over en
//   en            in   scan enable, low freezes the whole scan
//   h_cnt         out  current pixel column, 0..H_TOT-1
//   v_cnt         out  current line, 0..V_TOT-1
//   valid         out  high inside the visible area
//   hsync         out  horizontal sync, active-low
//   vsync         out  vertical sync, active-low
//   pix_tick      out  high in the last clk cycle of each pixel
//   frame_start   out  one-cycle pulse on re-entering (0,0) after a frame wrap
//   vblank_start  out  one-cycle pulse when v_cnt becomes V_VIS at h_cnt = 0
//   frame_cnt     out  completed-frame counter, wraps mod 2^16
// ---------------------------------------------------------------------------
module vga_scan_gen #(
    parameter int DIV   = 4,
    parameter int H_VIS = 640,
    parameter int H_FP  = 16,
    parameter int H_SW  = 96,
    parameter int H_BP  = 48,
    parameter int V_VIS = 480,
    parameter int V_FP  = 10,
    parameter int V_SW  = 2,
    parameter int V_BP  = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic        valid,
    output logic        hsync,
    output logic        vsync,
    output logic        pix_tick,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

    // Timing boundaries pre-sized to the counter widths so every compare
    // below is a plain 10-bit unsigned compare.
    localparam logic [3:0] DIV_LAST   = 4'(DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VIS - 1);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_VIS + H_FP + H_SW);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VIS + V_FP + V_SW);

    // Scan state.
    logic [3:0]  div_q,          div_d;
    logic [9:0]  h_q,            h_d;
    logic [9:0]  v_q,            v_d;
    logic [15:0] frame_cnt_q,    frame_cnt_d;

    // Registered decoded outputs.
    logic        valid_q,        valid_d;
    logic        hsync_q,        hsync_d;
    logic        vsync_q,        vsync_d;
    logic        pix_tick_q,     pix_tick_d;
    logic        frame_start_q,  frame_start_d;
    logic        vblank_start_q, vblank_start_d;

    // Qualified advance events at the coming edge.
    logic        pix_adv;
    logic        line_wrap;
    logic        frame_wrap;

    // The counters step only on an edge where en is high and the divider
    // sits on its last count. Holding every counter when en is low gives a
    // lossless freeze: the divider resumes from the count it stopped at.
    //
    // The decoded outputs are computed from the *next* counter values. This
    // way, after the edge, they describe the same position the counters
    // now show.
    //
    // pix_tick is high when the next divider value is the last one and en
    // was high, so it marks the final clk cycle of the pixel. When a freeze
    // lands on that last cycle, the tick has already been shown. On resume
    // the divider wraps straight to 0, so no second tick appears for that
    // pixel.
    always_comb begin
        pix_adv    = en && (div_q == DIV_LAST);
        line_wrap  = pix_adv && (h_q == H_LAST);
        frame_wrap = line_wrap && (v_q == V_LAST);

        div_d = div_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        end

        h_d = h_q;
        if (pix_adv) begin
            h_d = line_wrap ? 10'd0 : h_q + 10'd1;
        end

        v_d = v_q;
        if (line_wrap) begin
            v_d = frame_wrap ? 10'd0 : v_q + 10'd1;
        end

        frame_cnt_d = frame_wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;

        valid_d        = (h_d < H_VIS_END) && (v_d < V_VIS_END);
        hsync_d        = !((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END));
        vsync_d        = !((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END));
        pix_tick_d     = en && (div_d == DIV_LAST);
        frame_start_d  = frame_wrap;
        vblank_start_d = line_wrap && (v_q == V_VIS_LAST);

        if (rst) begin
            div_d          = 4'd0;
            h_d            = 10'd0;
            v_d            = 10'd0;
            frame_cnt_d    = 16'd0;
            valid_d        = 1'b0;
            hsync_d        = 1'b1;
            vsync_d        = 1'b1;
            pix_tick_d     = 1'b0;
            frame_start_d  = 1'b0;
            vblank_start_d = 1'b0;
        end
    end

    // Single register stage for the scan state and every output.
    always_ff @(posedge clk) begin
        div_q          <= div_d;
        h_q            <= h_d;
        v_q            <= v_d;
        frame_cnt_q    <= frame_cnt_d;
        valid_q        <= valid_d;
        hsync_q        <= hsync_d;
        vsync_q        <= vsync_d;
        pix_tick_q     <= pix_tick_d;
        frame_start_q  <= frame_start_d;
        vblank_start_q <= vblank_start_d;
    end

    assign h_cnt        = h_q;
    assign v_cnt        = v_q;
    assign valid        = valid_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign pix_tick     = pix_tick_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_gen
//
// Directed bench for vga_scan_gen with three instances on one clock:
//   a: default 640x480 timing, DIV = 4 (line-level timing, mid-line reset)
//   b: tiny 8x4 raster, DIV = 4, H_TOT = 16, V_TOT = 8, 512 clks per frame
//      (frame wrap, vblank, vsync, freeze/resume at the frame wrap)
//   c: default timing with DIV = 1 (pixel every clk, 800-clk line)
// Expected values are hand-computed from the timing parameters. Each
// instance has its own rst and en so the scenarios can be staged
// independently.
// ---------------------------------------------------------------------------
module tb_vga_scan_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, en_a, rst_b, en_b, rst_c, en_c;

    logic [9:0]  h_a, v_a, h_b, v_b, h_c, v_c;
    logic        valid_a, hs_a, vs_a, pix_a, fs_a, vb_a;
    logic        valid_b, hs_b, vs_b, pix_b, fs_b, vb_b;
    logic        valid_c, hs_c, vs_c, pix_c, fs_c, vb_c;
    logic [15:0] fc_a, fc_b, fc_c;

    int checks   = 0;
    int failures = 0;

    vga_scan_gen dut_a (
        .clk(clk), .rst(rst_a), .en(en_a),
        .h_cnt(h_a), .v_cnt(v_a), .valid(valid_a), .hsync(hs_a), .vsync(vs_a),
        .pix_tick(pix_a), .frame_start(fs_a), .vblank_start(vb_a), .frame_cnt(fc_a)
    );

    vga_scan_gen #(
        .DIV(4), .H_VIS(8), .H_FP(2), .H_SW(3), .H_BP(3),
        .V_VIS(4), .V_FP(1), .V_SW(2), .V_BP(1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b),
        .h_cnt(h_b), .v_cnt(v_b), .valid(valid_b), .hsync(hs_b), .vsync(vs_b),
        .pix_tick(pix_b), .frame_start(fs_b), .vblank_start(vb_b), .frame_cnt(fc_b)
    );

    vga_scan_gen #(.DIV(1)) dut_c (
        .clk(clk), .rst(rst_c), .en(en_c),
        .h_cnt(h_c), .v_cnt(v_c), .valid(valid_c), .hsync(hs_c), .vsync(vs_c),
        .pix_tick(pix_c), .frame_start(fs_c), .vblank_start(vb_c), .frame_cnt(fc_c)
    );

    // Advance n rising edges, then settle 1 time unit so outputs are sampled
    // away from the edge and new inputs are set up for the next one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int hs_low;
        int pix_cnt;
        int vis_cnt;
        int n;

        // Reset held with en high on every instance: reset must win.
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;
        applyStimulus(3);
        checkOutput("rst_a_h",     32'(h_a),     0);
        checkOutput("rst_a_v",     32'(v_a),     0);
        checkOutput("rst_a_valid", 32'(valid_a), 0);
        checkOutput("rst_a_hsync", 32'(hs_a),    1);
        checkOutput("rst_a_vsync", 32'(vs_a),    1);
        checkOutput("rst_a_pix",   32'(pix_a),   0);
        checkOutput("rst_a_fs",    32'(fs_a),    0);
        checkOutput("rst_a_vb",    32'(vb_a),    0);
        checkOutput("rst_a_fc",    32'(fc_a),    0);
        checkOutput("rst_c_pix",   32'(pix_c),   0);

        // Release all; e counts edges since release.
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        applyStimulus(1);   // e=1
        checkOutput("a_first_valid", 32'(valid_a), 1);
        checkOutput("a_first_h",     32'(h_a),     0);
        checkOutput("a_first_pix",   32'(pix_a),   0);
        checkOutput("a_first_fs",    32'(fs_a),    0);
        checkOutput("c_first_h",     32'(h_c),     1);
        checkOutput("c_first_pix",   32'(pix_c),   1);
        applyStimulus(2);   // e=3
        checkOutput("a_tick_pix", 32'(pix_a), 1);
        checkOutput("a_tick_h",   32'(h_a),   0);
        applyStimulus(1);   // e=4
        checkOutput("a_step_h",   32'(h_a),   1);
        checkOutput("a_step_pix", 32'(pix_a), 0);
        checkOutput("c_step_h",   32'(h_c),   4);

        applyStimulus(251); // e=255
        checkOutput("b_prevb_v",  32'(v_b),  3);
        checkOutput("b_prevb_vb", 32'(vb_b), 0);
        applyStimulus(1);   // e=256
        checkOutput("b_vb_pulse", 32'(vb_b),    1);
        checkOutput("b_vb_v",     32'(v_b),     4);
        checkOutput("b_vb_h",     32'(h_b),     0);
        checkOutput("b_vb_valid", 32'(valid_b), 0);
        applyStimulus(1);   // e=257
        checkOutput("b_vb_end", 32'(vb_b), 0);
        applyStimulus(62);  // e=319
        checkOutput("b_vs_before", 32'(vs_b), 1);
        applyStimulus(1);   // e=320
        checkOutput("b_vs_start", 32'(vs_b), 0);
        checkOutput("b_vs_v",     32'(v_b),  5);
        applyStimulus(127); // e=447
        checkOutput("b_vs_last", 32'(vs_b), 0);
        applyStimulus(1);   // e=448
        checkOutput("b_vs_end", 32'(vs_b), 1);
        applyStimulus(63);  // e=511
        checkOutput("b_prefs_fs", 32'(fs_b), 0);
        checkOutput("b_prefs_fc", 32'(fc_b), 0);
        applyStimulus(1);   // e=512
        checkOutput("b_fs_pulse", 32'(fs_b),    1);
        checkOutput("b_fs_h",     32'(h_b),     0);
        checkOutput("b_fs_v",     32'(v_b),     0);
        checkOutput("b_fs_fc",    32'(fc_b),    1);
        checkOutput("b_fs_valid", 32'(valid_b), 1);
        applyStimulus(1);   // e=513
        checkOutput("b_fs_end", 32'(fs_b), 0);

        applyStimulus(286); // e=799
        checkOutput("c_line_end_h", 32'(h_c),  799);
        checkOutput("c_line_end_v", 32'(v_c),  0);
        checkOutput("c_line_hs",    32'(hs_c), 1);
        applyStimulus(1);   // e=800
        checkOutput("c_wrap_h",   32'(h_c),   0);
        checkOutput("c_wrap_v",   32'(v_c),   1);
        checkOutput("c_wrap_pix", 32'(pix_c), 1);
        en_c = 1'b0;
        applyStimulus(1);   // e=801, c frozen
        checkOutput("c_frz_h",   32'(h_c),   0);
        checkOutput("c_frz_v",   32'(v_c),   1);
        checkOutput("c_frz_pix", 32'(pix_c), 0);
        en_c = 1'b1;

        applyStimulus(1758); // e=2559
        checkOutput("a_vis_last_h",     32'(h_a),     639);
        checkOutput("a_vis_last_valid", 32'(valid_a), 1);
        applyStimulus(1);    // e=2560
        checkOutput("a_blank_valid", 32'(valid_a), 0);
        applyStimulus(63);   // e=2623
        checkOutput("a_hs_before_h", 32'(h_a),  655);
        checkOutput("a_hs_before",   32'(hs_a), 1);
        applyStimulus(1);    // e=2624
        checkOutput("a_hs_start",   32'(hs_a), 0);
        checkOutput("a_hs_start_h", 32'(h_a),  656);
        applyStimulus(383);  // e=3007
        checkOutput("a_hs_last",   32'(hs_a), 0);
        checkOutput("a_hs_last_h", 32'(h_a),  751);
        applyStimulus(1);    // e=3008
        checkOutput("a_hs_end", 32'(hs_a), 1);
        applyStimulus(191);  // e=3199
        checkOutput("a_eol_h", 32'(h_a), 799);
        checkOutput("a_eol_v", 32'(v_a), 0);
        applyStimulus(1);    // e=3200
        checkOutput("a_wrap_h",     32'(h_a),     0);
        checkOutput("a_wrap_v",     32'(v_a),     1);
        checkOutput("a_wrap_valid", 32'(valid_a), 1);

        // One full line period (3200 clks) of instance a.
        hs_low = 0; pix_cnt = 0; vis_cnt = 0;
        for (int i = 0; i < 3200; i++) begin
            applyStimulus(1);
            if (!hs_a)   hs_low++;
            if (pix_a)   pix_cnt++;
            if (valid_a) vis_cnt++;
        end                  // e=6400
        checkOutput("a_line_hs_low", 32'(hs_low),  384);
        checkOutput("a_line_ticks",  32'(pix_cnt), 800);
        checkOutput("a_line_valid",  32'(vis_cnt), 2560);
        checkOutput("a_line2_h",     32'(h_a),     0);
        checkOutput("a_line2_v",     32'(v_a),     2);

        // Mid-line reset of instance a at h=300.
        applyStimulus(1200); // e=7600
        checkOutput("a_mid_h", 32'(h_a), 300);
        checkOutput("a_mid_v", 32'(v_a), 2);
        rst_a = 1'b1;
        applyStimulus(1);
        checkOutput("a_mrst_h",     32'(h_a),     0);
        checkOutput("a_mrst_v",     32'(v_a),     0);
        checkOutput("a_mrst_valid", 32'(valid_a), 0);
        checkOutput("a_mrst_hsync", 32'(hs_a),    1);
        checkOutput("a_mrst_pix",   32'(pix_a),   0);
        checkOutput("a_mrst_fs",    32'(fs_a),    0);
        rst_a = 1'b0;
        applyStimulus(1);
        checkOutput("a_restart_h",     32'(h_a),     0);
        checkOutput("a_restart_valid", 32'(valid_a), 1);
        checkOutput("a_restart_fs",    32'(fs_a),    0);
        applyStimulus(3);
        checkOutput("a_restart_step", 32'(h_a), 1);

        // Instance b: reset, run to (15,7) with div=2, then freeze 100 clks.
        rst_b = 1'b1;
        applyStimulus(1);
        checkOutput("b_rst_fc", 32'(fc_b), 0);
        checkOutput("b_rst_fs", 32'(fs_b), 0);
        checkOutput("b_rst_h",  32'(h_b),  0);
        rst_b = 1'b0;
        applyStimulus(510);
        checkOutput("b_prefrz_h", 32'(h_b), 15);
        checkOutput("b_prefrz_v", 32'(v_b), 7);
        en_b = 1'b0;
        applyStimulus(100);
        checkOutput("b_frz_h",     32'(h_b),     15);
        checkOutput("b_frz_v",     32'(v_b),     7);
        checkOutput("b_frz_pix",   32'(pix_b),   0);
        checkOutput("b_frz_valid", 32'(valid_b), 0);
        checkOutput("b_frz_hsync", 32'(hs_b),    1);
        checkOutput("b_frz_vsync", 32'(vs_b),    1);
        checkOutput("b_frz_fs",    32'(fs_b),    0);
        checkOutput("b_frz_fc",    32'(fc_b),    0);
        en_b = 1'b1;
        applyStimulus(1);
        checkOutput("b_res1_h",   32'(h_b),  15);
        checkOutput("b_res1_pix", 32'(pix_b), 1);
        checkOutput("b_res1_fs",  32'(fs_b), 0);
        applyStimulus(1);
        checkOutput("b_res2_fs", 32'(fs_b), 1);
        checkOutput("b_res2_h",  32'(h_b),  0);
        checkOutput("b_res2_v",  32'(v_b),  0);
        checkOutput("b_res2_fc", 32'(fc_b), 1);

        // Bounded wait for the next frame_start: period must be 512 clks.
        n = 0;
        do begin
            applyStimulus(1);
            n++;
        end while (!fs_b && n < 600);
        checkOutput("b_frame_period", 32'(n),    512);
        checkOutput("b_frame_fc2",    32'(fc_b), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
